// File: rtl/ex_stage_sched_pkg.sv
// ---------------------------------------------------------------------------
// ex_stage_sched_pkg
// Shared definitions for the EX0->EX1 stage sequencer.
// The sequencer has five states in a 3-bit encoding. The package also holds a
// helper that tells whether a state owns an in-flight division.
// ---------------------------------------------------------------------------
package ex_stage_sched_pkg;

  // Default width of the saturating stall-cycle counter
  localparam int STALL_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DIV_RUN   = 3'd1,
    ST_DIV_DONE  = 3'd2,
    ST_PRIV_WAIT = 3'd3,
    ST_EXC_DRAIN = 3'd4
  } sched_state_e;

  // In these states the shared divider belongs to the instruction held in
  // EX0. Leaving them through any flush or exception has to cancel it.
  function automatic logic is_div_state(input sched_state_e s);
    return (s == ST_DIV_RUN) || (s == ST_DIV_DONE);
  endfunction

endpackage

// File: rtl/ex_stage_sched_if.sv
// ---------------------------------------------------------------------------
// ex_stage_sched_if
// Handshake bundle between the EX0 pipeline context and the stage sequencer.
//   master : drives the EX0/EX1/flush status and divider/privilege readiness
//   slave  : the sequencer; drives divider control, stage register control,
//            excp_pending and the stall-cycle counter
// ---------------------------------------------------------------------------
interface ex_stage_sched_if
  import ex_stage_sched_pkg::*;
#(
  parameter int CNT_W = STALL_CNT_W
);

  logic             in_valid;
  logic             in_is_div;
  logic             in_is_priv;
  logic             priv_ready;
  logic             div_ready;
  logic             down_allowin;
  logic             fwd_stall;
  logic             ex1_excp;
  logic             flush;
  logic             flush_by_exception;

  logic             div_start;
  logic             div_abort;
  logic             stage_allowin;
  logic             stage_load;
  logic             stage_bubble;
  logic             excp_pending;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output in_valid, in_is_div, in_is_priv, priv_ready, div_ready,
           down_allowin, fwd_stall, ex1_excp, flush, flush_by_exception,
    input  div_start, div_abort, stage_allowin, stage_load, stage_bubble,
           excp_pending, stall_cnt
  );

  modport slave (
    input  in_valid, in_is_div, in_is_priv, priv_ready, div_ready,
           down_allowin, fwd_stall, ex1_excp, flush, flush_by_exception,
    output div_start, div_abort, stage_allowin, stage_load, stage_bubble,
           excp_pending, stall_cnt
  );

endinterface

// File: rtl/ex_stage_sched_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its maximum value instead of wrapping.
// It is cleared asynchronously.
//   clk_i    : clock, rising edge
//   areset_i : asynchronous clear, active-high
//   en_i     : count this cycle
//   count_o  : current count
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             areset_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  // Increment on enable unless all ones already, so the count saturates
  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/ex_stage_sched.sv
// ---------------------------------------------------------------------------
// ex_stage_sched
// Sequencer for the EX0->EX1 stage register. Each cycle it decides whether
// the register loads, holds or takes a bubble. It owns the shared iterative
// divider (start/abort), holds privileged ops until the resource is ready,
// and drains the stage after an exception is recorded in EX1.
//   clk, areset : clock and asynchronous active-high reset
//   bus         : ex_stage_sched_if.slave
//       inputs  : in_valid, in_is_div, in_is_priv, priv_ready, div_ready,
//                 down_allowin, fwd_stall, ex1_excp, flush,
//                 flush_by_exception
//       outputs : div_start, div_abort, stage_allowin, stage_load,
//                 stage_bubble, excp_pending, stall_cnt
// ---------------------------------------------------------------------------
module ex_stage_sched
  import ex_stage_sched_pkg::*;
#(
  parameter int CNT_W = STALL_CNT_W
) (
  input logic               clk,
  input logic               areset,
  ex_stage_sched_if.slave   bus
);

  sched_state_e     state_q, state_d;
  logic             excp_pending_q, excp_pending_d;

  logic             in_div_state;
  logic             flush_hit;
  logic             permitted;
  logic             allowin;
  logic             load;
  logic             bubble;
  logic             start;
  logic             abort;
  logic             stall_en;
  logic [CNT_W-1:0] stall_cnt_w;

  // Stage register control and divider handshakes come from the current
  // state and this cycle's inputs. A branch flush only acts once EX1 can
  // take the bubble. The one exception is a flush that lands together with
  // div_ready: the result is thrown away and the division is cancelled.
  always_comb begin
    in_div_state = is_div_state(state_q);
    flush_hit    = bus.flush & bus.down_allowin;

    permitted = ((state_q == ST_IDLE) & ~bus.in_is_div
                  & ~(bus.in_is_priv & ~bus.priv_ready))
              | (state_q == ST_DIV_DONE)
              | ((state_q == ST_PRIV_WAIT) & bus.priv_ready);

    allowin = bus.down_allowin & permitted & ~excp_pending_q & ~bus.ex1_excp;
    load    = allowin & bus.in_valid & ~bus.fwd_stall
            & ~bus.flush & ~bus.flush_by_exception;
    bubble  = bus.flush_by_exception | flush_hit
            | (bus.down_allowin & ~bus.fwd_stall & ~allowin);

    start = (state_q == ST_IDLE) & bus.in_valid & bus.in_is_div
          & ~excp_pending_q & ~bus.ex1_excp
          & ~bus.flush & ~bus.flush_by_exception;
    abort = (in_div_state
              & (bus.flush_by_exception | bus.ex1_excp | flush_hit))
          | ((state_q == ST_DIV_RUN) & bus.flush & bus.div_ready);

    stall_en = bubble & ~bus.flush & ~bus.flush_by_exception;
  end

  // Next state follows a fixed priority order, highest first:
  // exception flush, EX1 exception, branch flush, divider/privilege
  // readiness, and then issue of a new instruction.
  always_comb begin
    state_d        = state_q;
    excp_pending_d = excp_pending_q;
    if (bus.flush_by_exception) begin
      state_d        = ST_IDLE;
      excp_pending_d = 1'b0;
    end else if (bus.ex1_excp && (state_q != ST_EXC_DRAIN)) begin
      state_d        = ST_EXC_DRAIN;
      excp_pending_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_DIV_RUN;
          end else if (bus.in_valid & bus.in_is_priv & ~bus.priv_ready
                       & ~bus.flush) begin
            state_d = ST_PRIV_WAIT;
          end
        end
        ST_DIV_RUN: begin
          if (flush_hit | (bus.flush & bus.div_ready)) begin
            state_d = ST_IDLE;
          end else if (bus.div_ready) begin
            state_d = ST_DIV_DONE;
          end
        end
        ST_DIV_DONE, ST_PRIV_WAIT: begin
          if (flush_hit | load) begin
            state_d = ST_IDLE;
          end
        end
        ST_EXC_DRAIN: begin
          state_d = ST_EXC_DRAIN;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and the pending-exception flag are the only sequencer state.
  // Reset does not send an abort. The divider is reset separately.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q        <= ST_IDLE;
      excp_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      excp_pending_q <= excp_pending_d;
    end
  end

  sat_counter #(
    .CNT_W    (CNT_W)
  ) u_stall_cnt (
    .clk_i    (clk),
    .areset_i (areset),
    .en_i     (stall_en),
    .count_o  (stall_cnt_w)
  );

  // All outputs are held at zero while reset is asserted, including the
  // purely combinational controls.
  assign bus.div_start     = start & ~areset;
  assign bus.div_abort     = abort & ~areset;
  assign bus.stage_allowin = allowin & ~areset;
  assign bus.stage_load    = load & ~areset;
  assign bus.stage_bubble  = bubble & ~areset;
  assign bus.excp_pending  = excp_pending_q & ~areset;
  assign bus.stall_cnt     = areset ? '0 : stall_cnt_w;

endmodule

// File: tb/tb_ex_stage_sched.sv
// ---------------------------------------------------------------------------
// tb_ex_stage_sched
// Testbench for ex_stage_sched. Two instances share one input stream: one
// with the default 16-bit stall counter and one with a 2-bit counter that
// exercises saturation. A reference model of the stage rules predicts every
// output each cycle. Directed sequences cover the main scenarios, and a
// randomized run follows them.
// ---------------------------------------------------------------------------
module tb_ex_stage_sched;

  typedef struct packed {
    logic in_valid;
    logic in_is_div;
    logic in_is_priv;
    logic priv_ready;
    logic div_ready;
    logic down_allowin;
    logic fwd_stall;
    logic ex1_excp;
    logic flush;
    logic fbe;
  } stim_t;

  typedef struct packed {
    logic start;
    logic abort;
    logic allowin;
    logic load;
    logic bubble;
  } exp_t;

  typedef enum {M_FREE, M_DIVIDING, M_RESULT, M_PRIV, M_DRAIN} mode_e;

  logic clk;
  logic rst;

  ex_stage_sched_if #(.CNT_W(16)) bus1 ();
  ex_stage_sched_if #(.CNT_W(2))  bus2 ();

  ex_stage_sched #(.CNT_W(16)) dut1 (.clk(clk), .areset(rst), .bus(bus1));
  ex_stage_sched #(.CNT_W(2))  dut2 (.clk(clk), .areset(rst), .bus(bus2));

  assign bus2.in_valid           = bus1.in_valid;
  assign bus2.in_is_div          = bus1.in_is_div;
  assign bus2.in_is_priv         = bus1.in_is_priv;
  assign bus2.priv_ready         = bus1.priv_ready;
  assign bus2.div_ready          = bus1.div_ready;
  assign bus2.down_allowin       = bus1.down_allowin;
  assign bus2.fwd_stall          = bus1.fwd_stall;
  assign bus2.ex1_excp           = bus1.ex1_excp;
  assign bus2.flush              = bus1.flush;
  assign bus2.flush_by_exception = bus1.flush_by_exception;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;

  mode_e mMode    = M_FREE;
  bit    mPending = 1'b0;
  int    mStall   = 0;

  logic        lastStart, lastAbort, lastAllow, lastLoad, lastBubble, lastPend;
  logic [15:0] lastStall;
  logic [1:0]  lastStall2;

  // Every comparison in the bench goes through this task
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
               $time);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    bus1.in_valid           = s.in_valid;
    bus1.in_is_div          = s.in_is_div;
    bus1.in_is_priv         = s.in_is_priv;
    bus1.priv_ready         = s.priv_ready;
    bus1.div_ready          = s.div_ready;
    bus1.down_allowin       = s.down_allowin;
    bus1.fwd_stall          = s.fwd_stall;
    bus1.ex1_excp           = s.ex1_excp;
    bus1.flush              = s.flush;
    bus1.flush_by_exception = s.fbe;
  endtask

  function automatic stim_t base();
    stim_t s;
    s = '0;
    s.down_allowin = 1'b1;
    return s;
  endfunction

  // Expected outputs for the current model mode and these inputs
  function automatic exp_t modelOut(input stim_t s);
    exp_t e;
    bit   free, canPass, holdsDivider;
    free         = (mMode == M_FREE);
    holdsDivider = (mMode == M_DIVIDING) || (mMode == M_RESULT);
    canPass = (free && !s.in_is_div && !(s.in_is_priv && !s.priv_ready))
           || (mMode == M_RESULT)
           || (mMode == M_PRIV && s.priv_ready);
    e.allowin = s.down_allowin && canPass && !mPending && !s.ex1_excp;
    e.load    = e.allowin && s.in_valid && !s.fwd_stall && !s.flush && !s.fbe;
    e.bubble  = s.fbe || (s.flush && s.down_allowin)
             || (s.down_allowin && !s.fwd_stall && !e.allowin);
    e.start   = free && s.in_valid && s.in_is_div && !mPending
             && !s.ex1_excp && !s.flush && !s.fbe;
    e.abort   = (holdsDivider && (s.fbe || s.ex1_excp
                                  || (s.flush && s.down_allowin)))
             || (mMode == M_DIVIDING && s.flush && s.div_ready);
    return e;
  endfunction

  // Advance the model one clock, walking the events from highest priority
  task automatic modelStep(input stim_t s, input exp_t e);
    if (e.bubble && !s.flush && !s.fbe) mStall++;
    if (s.fbe) begin
      mMode    = M_FREE;
      mPending = 1'b0;
    end else if (s.ex1_excp && mMode != M_DRAIN) begin
      mMode    = M_DRAIN;
      mPending = 1'b1;
    end else if (s.flush && s.down_allowin && mMode != M_DRAIN
                 && mMode != M_FREE) begin
      mMode = M_FREE;
    end else if (mMode == M_DIVIDING && s.flush && s.div_ready) begin
      mMode = M_FREE;
    end else begin
      case (mMode)
        M_DIVIDING: if (s.div_ready) mMode = M_RESULT;
        M_RESULT:   if (e.load) mMode = M_FREE;
        M_PRIV:     if (e.load) mMode = M_FREE;
        M_FREE: begin
          if (e.start) mMode = M_DIVIDING;
          else if (s.in_valid && s.in_is_priv && !s.priv_ready && !s.flush)
            mMode = M_PRIV;
        end
        default: ;
      endcase
    end
  endtask

  function automatic int capStall(input int limit);
    return (mStall > limit) ? limit : mStall;
  endfunction

  // Drive one cycle. Compare both instances against the model before the
  // edge, then advance the model after the edge.
  task automatic runCycle(input stim_t s);
    exp_t e;
    applyStimulus(s);
    #2;
    e = modelOut(s);
    lastStart  = bus1.div_start;
    lastAbort  = bus1.div_abort;
    lastAllow  = bus1.stage_allowin;
    lastLoad   = bus1.stage_load;
    lastBubble = bus1.stage_bubble;
    lastPend   = bus1.excp_pending;
    lastStall  = bus1.stall_cnt;
    lastStall2 = bus2.stall_cnt;
    checkOutput("div_start",     32'(bus1.div_start),     32'(e.start));
    checkOutput("div_abort",     32'(bus1.div_abort),     32'(e.abort));
    checkOutput("stage_allowin", 32'(bus1.stage_allowin), 32'(e.allowin));
    checkOutput("stage_load",    32'(bus1.stage_load),    32'(e.load));
    checkOutput("stage_bubble",  32'(bus1.stage_bubble),  32'(e.bubble));
    checkOutput("excp_pending",  32'(bus1.excp_pending),  32'(mPending));
    checkOutput("stall_cnt",     32'(bus1.stall_cnt),     capStall(65535));
    checkOutput("w2_div_start",  32'(bus2.div_start),     32'(e.start));
    checkOutput("w2_div_abort",  32'(bus2.div_abort),     32'(e.abort));
    checkOutput("w2_allowin",    32'(bus2.stage_allowin), 32'(e.allowin));
    checkOutput("w2_load",       32'(bus2.stage_load),    32'(e.load));
    checkOutput("w2_bubble",     32'(bus2.stage_bubble),  32'(e.bubble));
    checkOutput("w2_pending",    32'(bus2.excp_pending),  32'(mPending));
    checkOutput("w2_stall_cnt",  32'(bus2.stall_cnt),     capStall(3));
    @(posedge clk);
    #1;
    modelStep(s, e);
  endtask

  // Hold reset across one clock edge while driving inputs that would
  // otherwise raise outputs. Every output must stay at zero.
  task automatic doReset(input stim_t s);
    rst = 1'b1;
    applyStimulus(s);
    #2;
    checkOutput("rst_div_start", 32'(bus1.div_start),     0);
    checkOutput("rst_div_abort", 32'(bus1.div_abort),     0);
    checkOutput("rst_allowin",   32'(bus1.stage_allowin), 0);
    checkOutput("rst_load",      32'(bus1.stage_load),    0);
    checkOutput("rst_bubble",    32'(bus1.stage_bubble),  0);
    checkOutput("rst_pending",   32'(bus1.excp_pending),  0);
    checkOutput("rst_stall",     32'(bus1.stall_cnt),     0);
    checkOutput("rst_w2_stall",  32'(bus2.stall_cnt),     0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    mMode    = M_FREE;
    mPending = 1'b0;
    mStall   = 0;
  endtask

  initial begin
    stim_t s;
    rst = 1'b1;

    $display("[TB] reset");
    s = base();
    s.fbe = 1'b1;
    doReset(s);

    $display("[TB] divide issue and completion");
    s = base();
    s.in_valid  = 1'b1;
    s.in_is_div = 1'b1;
    runCycle(s);
    checkOutput("div_t0_start", 32'(lastStart), 1);
    checkOutput("div_t0_allowin", 32'(lastAllow), 0);
    for (int i = 1; i < 17; i++) runCycle(s);
    s.div_ready = 1'b1;
    runCycle(s);
    s.div_ready = 1'b0;
    runCycle(s);
    checkOutput("div_t18_load", 32'(lastLoad), 1);
    runCycle(base());

    $display("[TB] flush during divide");
    s = base();
    s.in_valid  = 1'b1;
    s.in_is_div = 1'b1;
    for (int i = 0; i < 5; i++) runCycle(s);
    s.flush = 1'b1;
    runCycle(s);
    checkOutput("flush_abort", 32'(lastAbort), 1);
    checkOutput("flush_bubble", 32'(lastBubble), 1);
    checkOutput("flush_no_start", 32'(lastStart), 0);
    s = base();
    s.in_valid = 1'b1;
    runCycle(s);
    checkOutput("flush_idle_allowin", 32'(lastAllow), 1);

    $display("[TB] EX1 exception drain");
    s = base();
    s.in_valid = 1'b1;
    for (int t = 0; t < 3; t++) runCycle(s);
    s.ex1_excp = 1'b1;
    for (int t = 3; t <= 9; t++) begin
      if (t == 9) s.fbe = 1'b1;
      runCycle(s);
      checkOutput("drain_allowin", 32'(lastAllow), 0);
      if (t >= 4) checkOutput("drain_pending", 32'(lastPend), 1);
    end
    s = base();
    s.in_valid = 1'b1;
    runCycle(s);
    checkOutput("drain_t10_allowin", 32'(lastAllow), 1);
    checkOutput("drain_t10_pending", 32'(lastPend), 0);

    $display("[TB] privileged op wait");
    doReset(base());
    s = base();
    s.in_valid   = 1'b1;
    s.in_is_priv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      runCycle(s);
      checkOutput("priv_bubble", 32'(lastBubble), 1);
    end
    s.priv_ready = 1'b1;
    runCycle(s);
    checkOutput("priv_load", 32'(lastLoad), 1);
    checkOutput("priv_stall_cnt", 32'(lastStall), 4);

    $display("[TB] narrow counter saturation");
    doReset(base());
    s = base();
    s.in_is_priv = 1'b1;
    runCycle(s);
    for (int k = 1; k <= 5; k++) begin
      int want;
      want = (k < 3) ? k : 3;
      runCycle(s);
      checkOutput("w2_saturate", 32'(lastStall2), want);
    end

    $display("[TB] div_ready with exception flush");
    s = base();
    s.in_valid  = 1'b1;
    s.in_is_div = 1'b1;
    for (int i = 0; i < 4; i++) runCycle(s);
    s.div_ready = 1'b1;
    s.fbe       = 1'b1;
    runCycle(s);
    checkOutput("fbe_abort", 32'(lastAbort), 1);
    checkOutput("fbe_no_load", 32'(lastLoad), 0);
    s = base();
    s.in_valid = 1'b1;
    runCycle(s);
    checkOutput("fbe_idle_allowin", 32'(lastAllow), 1);

    $display("[TB] reset during divide");
    s = base();
    s.in_valid  = 1'b1;
    s.in_is_div = 1'b1;
    for (int i = 0; i < 3; i++) runCycle(s);
    s.fbe = 1'b1;
    doReset(s);
    s = base();
    s.in_valid = 1'b1;
    runCycle(s);
    checkOutput("post_rst_allowin", 32'(lastAllow), 1);

    $display("[TB] randomized run");
    for (int n = 0; n < 3000; n++) begin
      s = '0;
      s.in_valid     = ($urandom_range(0, 9) < 7);
      s.in_is_div    = ($urandom_range(0, 19) < 3);
      s.in_is_priv   = ($urandom_range(0, 19) < 3);
      s.priv_ready   = ($urandom_range(0, 9) < 6);
      s.div_ready    = ($urandom_range(0, 9) < 1);
      s.down_allowin = ($urandom_range(0, 9) < 8);
      s.fwd_stall    = ($urandom_range(0, 19) < 3);
      s.ex1_excp     = ($urandom_range(0, 99) < 3);
      s.flush        = ($urandom_range(0, 99) < 5);
      s.fbe          = mPending ? ($urandom_range(0, 9) < 2)
                                : ($urandom_range(0, 99) < 2);
      runCycle(s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
